// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: queues command bytes and sends each as an 11-bit frame with ACK check.
// Optional ps2 clock glitch filter enabled by defining PS2_TX_FILTER_EN.
module ps2_host_tx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 750000
`ifdef PS2_TX_FILTER_EN
    ,
    parameter int FILTER_CYC  = 8
`endif
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_en_i,
    input  logic [7:0] wr_data_i,
    input  logic       err_clr_i,
    output logic       full_o,
    output logic       empty_o,
    output logic       busy_o,
    output logic       tx_done_o,
    output logic       tx_err_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW:0]      PTR_ONE  = (AW + 1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_REQ, S_ACK, S_WAIT} state_t;

    // Write handshake: wr_en_i is valid, a byte is taken on any cycle where the queue is
    // not full or the FSM pops that same cycle; otherwise the byte is dropped.
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic        w_empty, w_full, w_push, w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = wr_en_i && (!w_full || w_pop);

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Pins idle high, so synchronizers start high to avoid a false fall after reset.
    logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2, r_clk_prev;
    logic w_clk_lvl, w_fall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            {r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2} <= 4'b1111;
        end else begin
            r_clk_s1 <= ps2_clk_i;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data_i;
            r_dat_s2 <= r_dat_s1;
        end
    end

`ifdef PS2_TX_FILTER_EN
    localparam int FW = $clog2(FILTER_CYC + 1);
    logic [FW-1:0] r_filt_cnt;
    logic          r_clk_filt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_filt_cnt <= '0;
            r_clk_filt <= 1'b1;
        end else if (r_clk_s2 == r_clk_filt) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == FW'(FILTER_CYC - 1)) begin
            r_clk_filt <= r_clk_s2;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + FW'(1);
        end
    end
    assign w_clk_lvl = r_clk_filt;
`else
    assign w_clk_lvl = r_clk_s2;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) r_clk_prev <= 1'b1;
        else       r_clk_prev <= w_clk_lvl;
    end
    assign w_fall = r_clk_prev && !w_clk_lvl;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_bitn, w_bitn_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_parity, w_parity_nxt;
    logic             r_clk_oe, w_clk_oe_nxt;
    logic             r_data_oe, w_data_oe_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;
    logic             w_fail;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bitn    <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bitn    <= w_bitn_nxt;
            r_shift   <= w_shift_nxt;
            r_parity  <= w_parity_nxt;
            r_clk_oe  <= w_clk_oe_nxt;
            r_data_oe <= w_data_oe_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bitn_nxt    = r_bitn;
        w_shift_nxt   = r_shift;
        w_parity_nxt  = r_parity;
        w_clk_oe_nxt  = r_clk_oe;
        w_data_oe_nxt = r_data_oe;
        w_done_nxt    = 1'b0;
        w_fail        = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_nxt  = r_mem[r_rd_ptr[AW-1:0]];
                    w_parity_nxt = ~^r_mem[r_rd_ptr[AW-1:0]];
                    w_clk_oe_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_cnt == INH_LAST) begin
                    w_clk_oe_nxt  = 1'b0;
                    w_data_oe_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_bitn_nxt    = '0;
                    w_state_nxt   = S_REQ;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_REQ, S_ACK, S_WAIT: begin
                w_cnt_nxt = r_cnt + CNT_ONE;
                if (r_state == S_REQ && w_fall) begin
                    w_bitn_nxt = r_bitn + 4'd1;
                    if (r_bitn < 4'd8) begin
                        w_data_oe_nxt = ~r_shift[0];
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                    end else if (r_bitn == 4'd8) begin
                        w_data_oe_nxt = ~r_parity;
                    end else begin
                        w_data_oe_nxt = 1'b0;
                        w_state_nxt   = S_ACK;
                    end
                end else if (r_state == S_ACK && w_fall) begin
                    if (!r_dat_s2) w_state_nxt = S_WAIT;
                    else           w_fail      = 1'b1;
                end else if (r_state == S_WAIT && r_clk_s2 && r_dat_s2) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                if (r_cnt == TMO_LAST) begin
                    w_fail     = 1'b1;
                    w_done_nxt = 1'b0;
                end
                if (w_fail) begin
                    w_clk_oe_nxt  = 1'b0;
                    w_data_oe_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A fresh error outranks a clear in the same cycle.
        w_err_nxt = (r_err && !err_clr_i) || w_fail;
    end

    assign full_o        = w_full;
    assign empty_o       = w_empty;
    assign busy_o        = (r_state != S_IDLE);
    assign tx_done_o     = r_done;
    assign tx_err_o      = r_err;
    assign ps2_clk_oe_o  = r_clk_oe;
    assign ps2_data_oe_o = r_data_oe;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model (scaled timing).
// Glitch scenario expectations follow PS2_TX_FILTER_EN as defined for the build.
module tb_ps2_host_tx;
    localparam int INH  = 50;
    localparam int TMO  = 2000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_i, wr_en_i, err_clr_i;
    logic [7:0] wr_data_i;
    logic       full_o, empty_o, busy_o, tx_done_o, tx_err_o;
    logic       ps2_clk_oe_o, ps2_data_oe_o;
    logic       dev_clk, dev_dat;
    logic       ps2_clk_line, ps2_data_line;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign ps2_clk_line  = dev_clk & ~ps2_clk_oe_o;
    assign ps2_data_line = dev_dat & ~ps2_data_oe_o;

    ps2_host_tx #(.FIFO_DEPTH(8), .INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
        .err_clr_i(err_clr_i), .full_o(full_o), .empty_o(empty_o), .busy_o(busy_o),
        .tx_done_o(tx_done_o), .tx_err_o(tx_err_o),
        .ps2_clk_i(ps2_clk_line), .ps2_data_i(ps2_data_line),
        .ps2_clk_oe_o(ps2_clk_oe_o), .ps2_data_oe_o(ps2_data_oe_o)
    );

    always @(negedge clk) if (tx_done_o === 1'b1) done_cnt++;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_en_i   = 1'b1;
        wr_data_i = d;
        tick();
        wr_en_i   = 1'b0;
    endtask

    task automatic clear_err();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
    endtask

    task automatic wait_request();
        bit ok = 1'b0;
        for (int i = 0; i < INH + 100; i++) begin
            if (ps2_data_oe_o && !ps2_clk_oe_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL wait_request: got no request, want request within %0d cycles", INH + 100);
        end
    endtask

    task automatic dev_pulse(input bit ack_low, input bit glitch, output logic smp);
        if (glitch) begin
            repeat (8) tick();
            dev_clk = 1'b0;
            repeat (3) tick();
            dev_clk = 1'b1;
            repeat (HALF - 11) tick();
        end else begin
            repeat (HALF) tick();
        end
        smp = ps2_data_line;
        if (ack_low) dev_dat = 1'b0;
        dev_clk = 1'b0;
        repeat (HALF) tick();
        dev_clk = 1'b1;
    endtask

    task automatic device_frame(input bit ack, input int glitch_k, output logic [10:0] bits);
        logic s;
        bits = '0;
        for (int k = 1; k <= 11; k++) begin
            dev_pulse(ack && (k == 11), glitch_k == k, s);
            bits[k-1] = s;
        end
        repeat (HALF) tick();
        dev_dat = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; wr_en_i = 1'b0; wr_data_i = '0; err_clr_i = 1'b0;
        dev_clk = 1'b1; dev_dat = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        n_checks++; if (full_o !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b want 0", full_o); end
        n_checks++; if (empty_o !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b want 1", empty_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (tx_done_o !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", tx_done_o); end
        n_checks++; if (tx_err_o !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", tx_err_o); end
        n_checks++; if ({ps2_clk_oe_o, ps2_data_oe_o} !== 2'b00) begin n_errors++; $display("FAIL reset_oe: got %b want 00", {ps2_clk_oe_o, ps2_data_oe_o}); end
    endtask

    task automatic test_send_ed();
        int d0 = done_cnt;
        int n  = 0;
        logic [10:0] bits;
        push_byte(8'hED);
        for (int i = 0; i < 10 && !ps2_clk_oe_o; i++) tick();
        while (ps2_clk_oe_o && n < INH + 10) begin tick(); n++; end
        n_checks++; if (n !== INH) begin n_errors++; $display("FAIL ed_inhibit_len: got %0d want %0d", n, INH); end
        n_checks++; if (ps2_data_oe_o !== 1'b1) begin n_errors++; $display("FAIL ed_start_bit: got data_oe %b want 1", ps2_data_oe_o); end
        device_frame(1'b1, 0, bits);
        n_checks++; if (bits !== 11'h7DA) begin n_errors++; $display("FAIL ed_frame: got %h want 7da", bits); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_errors++; $display("FAIL ed_done: got %0d pulses want 1", done_cnt - d0); end
        n_checks++; if (tx_err_o !== 1'b0) begin n_errors++; $display("FAIL ed_err: got %b want 0", tx_err_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL ed_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_timeout();
        int d0 = done_cnt;
        int n  = 0;
        push_byte(8'hFF);
        wait_request();
        while (!tx_err_o && n < TMO + 20) begin tick(); n++; end
        n_checks++; if (n !== TMO) begin n_errors++; $display("FAIL tmo_cycles: got %0d want %0d", n, TMO); end
        n_checks++; if ({ps2_clk_oe_o, ps2_data_oe_o} !== 2'b00) begin n_errors++; $display("FAIL tmo_oe: got %b want 00", {ps2_clk_oe_o, ps2_data_oe_o}); end
        n_checks++; if (empty_o !== 1'b1) begin n_errors++; $display("FAIL tmo_empty: got %b want 1", empty_o); end
        n_checks++; if (done_cnt !== d0) begin n_errors++; $display("FAIL tmo_done: got %0d pulses want 0", done_cnt - d0); end
        clear_err();
        n_checks++; if (tx_err_o !== 1'b0) begin n_errors++; $display("FAIL tmo_err_clr: got %b want 0", tx_err_o); end
    endtask

    task automatic test_no_ack();
        int d0 = done_cnt;
        logic [10:0] bits;
        push_byte(8'h00);
        wait_request();
        device_frame(1'b0, 0, bits);
        n_checks++; if (bits !== 11'h600) begin n_errors++; $display("FAIL noack_frame: got %h want 600", bits); end
        n_checks++; if (tx_err_o !== 1'b1) begin n_errors++; $display("FAIL noack_err: got %b want 1", tx_err_o); end
        n_checks++; if (done_cnt !== d0) begin n_errors++; $display("FAIL noack_done: got %0d pulses want 0", done_cnt - d0); end
        clear_err();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  vals [9] = '{8'h01, 8'h80, 8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h5A, 8'hC3, 8'h7E};
        logic [10:0] bits, want;
        logic [7:0]  d;
        int d0 = done_cnt;
        for (int i = 0; i < 9; i++) begin
            wr_en_i   = 1'b1;
            wr_data_i = vals[i];
            exp_q.push_back(vals[i]);
            tick();
        end
        wr_en_i = 1'b0;
        n_checks++; if (full_o !== 1'b1) begin n_errors++; $display("FAIL b2b_full: got %b want 1", full_o); end
        push_byte(8'h55);
        n_checks++; if (full_o !== 1'b1) begin n_errors++; $display("FAIL b2b_full_drop: got %b want 1", full_o); end
        for (int i = 0; i < 9; i++) begin
            wait_request();
            device_frame(1'b1, 0, bits);
            d    = exp_q.pop_front();
            want = {1'b1, ~^d, d, 1'b0};
            n_checks++; if (bits !== want) begin n_errors++; $display("FAIL b2b_frame%0d: got %h want %h", i, bits, want); end
        end
        repeat (INH + 20) tick();
        n_checks++; if (done_cnt - d0 !== 9) begin n_errors++; $display("FAIL b2b_done: got %0d pulses want 9", done_cnt - d0); end
        n_checks++; if (empty_o !== 1'b1) begin n_errors++; $display("FAIL b2b_empty: got %b want 1", empty_o); end
        n_checks++; if (tx_err_o !== 1'b0) begin n_errors++; $display("FAIL b2b_err: got %b want 0", tx_err_o); end
    endtask

    task automatic test_reset_mid_frame();
        int   d0 = done_cnt;
        logic s;
        push_byte(8'h96);
        push_byte(8'h42);
        wait_request();
        for (int k = 1; k <= 4; k++) dev_pulse(1'b0, 1'b0, s);
        repeat (HALF) tick();
        dev_clk = 1'b0;
        repeat (2) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_checks++; if ({ps2_clk_oe_o, ps2_data_oe_o} !== 2'b00) begin n_errors++; $display("FAIL rstmid_oe: got %b want 00", {ps2_clk_oe_o, ps2_data_oe_o}); end
        n_checks++; if (empty_o !== 1'b1) begin n_errors++; $display("FAIL rstmid_empty: got %b want 1", empty_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
        dev_clk = 1'b1;
        repeat (HALF) tick();
        n_checks++; if (done_cnt !== d0 || tx_err_o !== 1'b0) begin n_errors++; $display("FAIL rstmid_no_done_err: got done %0d err %b want 0 0", done_cnt - d0, tx_err_o); end
    endtask

    task automatic test_glitch();
        int d0 = done_cnt;
        logic [10:0] bits;
        push_byte(8'h5A);
        wait_request();
        device_frame(1'b1, 4, bits);
`ifdef PS2_TX_FILTER_EN
        n_checks++; if (bits !== 11'h6B4) begin n_errors++; $display("FAIL glitch_frame: got %h want 6b4", bits); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_errors++; $display("FAIL glitch_done: got %0d pulses want 1", done_cnt - d0); end
        n_checks++; if (tx_err_o !== 1'b0) begin n_errors++; $display("FAIL glitch_err: got %b want 0", tx_err_o); end
`else
        n_checks++; if (tx_err_o !== 1'b1) begin n_errors++; $display("FAIL glitch_err: got %b want 1", tx_err_o); end
        n_checks++; if (done_cnt !== d0) begin n_errors++; $display("FAIL glitch_done: got %0d pulses want 0", done_cnt - d0); end
`endif
        clear_err();
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_timeout();
        test_no_ack();
        test_back_to_back();
        test_reset_mid_frame();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
